// File: rtl/console_uart_tx.sv
// Memory-mapped console UART transmitter: byte stores feed a TX FIFO drained as 8N1 frames.
// Define CONSOLE_STATUS_EN to expose a clear-on-read status register at BASE_ADDR+4.
module console_uart_tx #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_write,
  output logic [31:0] mem_rdata,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLK_DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_next;
  logic [BAUD_W-1:0] baud, baud_next;
  logic [2:0]        bit_idx, bit_idx_next;
  logic [7:0]        shift, shift_next;
  logic              tx_next;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full, empty, push, push_ok, pop, baud_last;
  logic              overflow, status_rd_q;
  logic              unused_bits;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign baud_last = (baud == BAUD_W'(CLK_DIV - 1));
  assign push      = (mem_addr == BASE_ADDR) && mem_write[0];
  // A full FIFO still takes a byte when the FSM pops on the same edge.
  assign push_ok   = push && (!full || pop);
  assign pop       = !empty && ((state == IDLE) || (state == STOP && baud_last));
  assign busy      = !empty || (state != IDLE);

  // NOTE: storage array has no reset; pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= mem_wdata[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       overflow <= 1'b0;
    else if (push && full && !pop)   overflow <= 1'b1;
    else if (status_rd_q)            overflow <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
      tx      <= tx_next;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next   = state;
    baud_next    = baud;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_next = START;
          baud_next  = '0;
          shift_next = fifo_mem[rd_ptr];
        end
      end
      START: begin
        if (baud_last) begin
          state_next   = DATA;
          baud_next    = '0;
          bit_idx_next = '0;
        end else begin
          baud_next = baud + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            shift_next   = {1'b0, shift[7:1]};
          end
        end else begin
          baud_next = baud + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_next = '0;
          if (!empty) begin
            state_next = START;
            shift_next = fifo_mem[rd_ptr];
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud + BAUD_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // tx is computed from the next state so the registered line changes on the same edge.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      IDLE:    tx_next = 1'b1;
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      STOP:    tx_next = 1'b1;
      default: tx_next = 1'b1;
    endcase
  end

`ifdef CONSOLE_STATUS_EN
  logic status_hit;
  assign status_hit = (mem_addr == BASE_ADDR + 32'd4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rdata   <= '0;
      status_rd_q <= 1'b0;
    end else begin
      status_rd_q <= status_hit;
      mem_rdata   <= status_hit ? {28'd0, overflow, busy, empty, full} : 32'd0;
    end
  end

  assign unused_bits = ^{mem_wdata[31:8], mem_write[3:1]};
`else
  assign mem_rdata   = '0;
  assign status_rd_q = 1'b0;
  assign unused_bits = ^{mem_wdata[31:8], mem_write[3:1], overflow};
`endif

endmodule

// File: tb/tb_console_uart_tx.sv
// Directed bench for console_uart_tx at CLK_DIV=4, FIFO_DEPTH=8; decodes every frame on tx.
// Status expectations collapse to 0 when CONSOLE_STATUS_EN is not defined.
module tb_console_uart_tx;

  localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef CONSOLE_STATUS_EN
  localparam logic [31:0] STATUS_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] STATUS_MASK = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_write;
  logic        tx, busy;
  int          checks = 0;
  int          errors = 0;

  console_uart_tx #(.CLK_DIV(4), .FIFO_DEPTH(8), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] status_exp(input logic [3:0] bits);
    return {28'd0, bits} & STATUS_MASK;
  endfunction

  // Drives one bus cycle, consumes one rising edge, returns 1 time unit after it.
  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    mem_addr = a; mem_wdata = d; mem_write = we;
    @(posedge clk); #1;
    mem_addr = '0; mem_wdata = '0; mem_write = '0;
  endtask

  // Called just after the edge where the start bit appears; returns just after the edge 40 later.
  task automatic expect_frame(input logic [7:0] b);
    logic exp_bit;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (i < 4)       exp_bit = 1'b0;
      else if (i < 36) exp_bit = b[(i - 4) / 4];
      else             exp_bit = 1'b1;
      checks++;
      if ({tx, busy} !== {exp_bit, 1'b1}) begin
        errors++;
        $display("FAIL frame_%h cycle %0d: tx/busy=%b%b expected %b1", b, i, tx, busy, exp_bit);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({tx, busy} !== 2'b10) begin
      errors++;
      $display("FAIL %s: tx/busy=%b%b expected 10", name, tx, busy);
    end
  endtask

  task automatic check_rdata(input string name, input logic [31:0] exp);
    checks++;
    if (mem_rdata !== exp) begin
      errors++;
      $display("FAIL %s: mem_rdata=%h expected %h", name, mem_rdata, exp);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_addr = '0; mem_wdata = '0; mem_write = '0;
    #3;
    check_idle("reset_async");
    check_rdata("reset_rdata", 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset_held");
    reset = 1'b0;
    @(posedge clk); #1;
    check_idle("reset_released");
    check_rdata("reset_released_rdata", 32'd0);
  endtask

  task automatic test_single;
    bus(BASE, 32'h0000_0041, 4'b0001);
    checks++;
    if ({tx, busy} !== 2'b11) begin
      errors++;
      $display("FAIL single_push_edge: tx/busy=%b%b expected 11", tx, busy);
    end
    @(posedge clk); #1;
    expect_frame(8'h41);
    check_idle("single_after_frame");
  endtask

  task automatic test_back_to_back;
    fork
      begin
        bus(BASE, 32'h48, 4'b0001);
        bus(BASE, 32'h69, 4'b0001);
        bus(BASE, 32'h0A, 4'b0001);
      end
      begin
        @(posedge clk); @(posedge clk); #1;
        expect_frame(8'h48);
        expect_frame(8'h69);
        expect_frame(8'h0A);
      end
    join
    check_idle("b2b_after_frames");
  endtask

  task automatic test_ignored;
    bus(BASE, 32'h55, 4'b0010);
    check_idle("ignored_upper_strobe");
    bus(BASE + 32'd8, 32'h55, 4'b0001);
    check_idle("ignored_other_addr");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_idle("ignored_idle");
    end
  endtask

  task automatic test_overflow;
    fork
      begin
        for (int k = 0; k < 10; k++) bus(BASE, 32'h30 + k, 4'b1111);
        bus(BASE + 32'd4, 32'd0, 4'b0000);
        check_rdata("overflow_status", status_exp(4'hD));
        @(posedge clk); #1;
        bus(BASE + 32'd4, 32'd0, 4'b0000);
        check_rdata("overflow_cleared", status_exp(4'h5));
      end
      begin
        @(posedge clk); @(posedge clk); #1;
        for (int k = 0; k < 9; k++) expect_frame(8'h30 + 8'(k));
      end
    join
    check_idle("overflow_tenth_dropped");
  endtask

  task automatic test_reset_mid;
    bus(BASE, 32'h11, 4'b0001);
    bus(BASE, 32'h22, 4'b0001);
    bus(BASE, 32'h33, 4'b0001);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if ({tx, busy} !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid_before: tx/busy=%b%b expected 01", tx, busy);
    end
    #2 reset = 1'b1;
    #1;
    check_idle("reset_mid_async");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    bus(BASE + 32'd4, 32'd0, 4'b0000);
    check_rdata("reset_mid_status", status_exp(4'h2));
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check_idle("reset_mid_discarded");
    end
  endtask

  task automatic test_full_pop;
    fork
      begin
        for (int k = 0; k < 9; k++) bus(BASE, 32'h50 + k, 4'b0001);
        repeat (32) @(posedge clk);
        #1;
        bus(BASE, 32'h59, 4'b0001);
        bus(BASE + 32'd4, 32'd0, 4'b0000);
        check_rdata("full_pop_status", status_exp(4'h5));
      end
      begin
        @(posedge clk); @(posedge clk); #1;
        for (int k = 0; k < 10; k++) expect_frame(8'h50 + 8'(k));
      end
    join
    check_idle("full_pop_after_frames");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignored();
    test_overflow();
    test_reset_mid();
    test_full_pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/console_uart_tx.md
CONSOLE_UART_TX -- requirements
Module: console_uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16: clocks per serial bit; legal values are 2 or more.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: TX FIFO entries; legal values are powers of 2, 2 or more.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h1000_0000: TX data register address.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port mem_addr, input, 32 bits: CPU data address.
REQ-007 SHALL have port mem_wdata, input, 32 bits: CPU store data.
REQ-008 SHALL have port mem_write, input, 4 bits: CPU byte write strobes.
REQ-009 SHALL have port mem_rdata, output, 32 bits: registered read data for the status register.
REQ-010 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-011 SHALL have port busy, output, 1 bit: high when the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-012 SHALL push mem_wdata[7:0] into the FIFO on a rising edge where mem_addr == BASE_ADDR and mem_write[0] == 1; mem_write[3:1] are ignored.
REQ-013 SHALL drop a push when the FIFO is full and no pop occurs that cycle, and SHALL set sticky flag overflow.
REQ-014 SHALL accept a push in the same cycle as a pop when the FIFO is full; count is unchanged.
REQ-015 SHALL use a circular FIFO whose read and write pointers wrap modulo FIFO_DEPTH, and SHALL hold a count of width clog2(FIFO_DEPTH)+1.
REQ-016 SHALL run an FSM with states IDLE, START, DATA and STOP, and a baud counter counting 0..CLK_DIV-1.
REQ-017 SHALL leave IDLE when the FIFO is non-empty: pop the head into a shift register, go to START and clear the baud counter, all on the same edge.
REQ-018 SHALL drive tx as follows: 1 in IDLE, 0 in START, shift register bit 0 in DATA, 1 in STOP; tx is registered.
REQ-019 SHALL hold each state or bit for exactly CLK_DIV cycles and send 8 data bits LSB first, tracked by a 3-bit bit index.
REQ-020 SHALL, at the end of STOP, go directly to START if the FIFO is non-empty (no idle gap), otherwise go to IDLE.
REQ-021 SHALL give a frame of 10*CLK_DIV cycles; a push into an empty FIFO with the FSM in IDLE at edge N SHALL drive tx low from edge N+1.
REQ-022 SHALL capture mem_rdata one cycle after the address, matching the data memory's read latency; when the address is not decoded, mem_rdata SHALL be 0.

Reset
REQ-023 SHALL, while reset is high, asynchronously set: FSM to IDLE, tx=1, busy=0, mem_rdata=0, FIFO pointers and count to 0, overflow=0, baud counter and bit index to 0.
REQ-024 SHALL abort any frame in progress when reset is asserted mid-frame; tx returns to 1 immediately, and queued bytes are discarded.
REQ-025 SHALL ignore pushes in the cycle reset deasserts unless reset is low at that rising edge.

Configuration
REQ-026 SHALL, with macro CONSOLE_STATUS_EN defined, decode BASE_ADDR+4 as a read-only status register: bit0 full, bit1 empty, bit2 busy, bit3 overflow, other bits 0.
REQ-027 SHALL clear overflow on the edge after a status read is captured (clear-on-read); a simultaneous overflow event SHALL win and keep overflow set.
REQ-028 SHALL, without CONSOLE_STATUS_EN, hold mem_rdata at constant 0; overflow is still tracked internally but not visible.

Verification (CLK_DIV=4, FIFO_DEPTH=8)
REQ-029 SHALL cover: store 0x41 to 0x1000_0000 from idle -> tx low at next edge, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then stop high; busy low after 40 cycles.
REQ-030 SHALL cover: 3 back-to-back stores 0x48, 0x69, 0x0A -> 3 contiguous 40-cycle frames in order, with no idle cycles between them.
REQ-031 SHALL cover: 10 stores in consecutive cycles -> first byte pops immediately, FIFO takes 8 more, 10th byte dropped; 9 frames sent; status read returns 0x0D (full, busy, overflow), then the next read shows bit3=0.
REQ-032 SHALL cover: store with mem_write=4'b0010 to 0x1000_0000, and store to 0x1000_0008 -> no push, tx stays 1, busy stays 0.
REQ-033 SHALL cover: reset asserted mid-DATA with 2 bytes queued -> tx=1 and busy=0 without waiting for a clock edge; after release, status reads 0x02.
REQ-034 SHALL cover: FIFO full, push coinciding with the STOP-to-START pop -> push accepted, count stays 8, overflow stays 0.
